// File: rtl/wb_sb_pkg.sv
// Shared types for the writeback scoreboard: FSM states, error codes and the
// expected-table entry payload.
package wb_sb_pkg;

  // Field widths of the stored expected entry; the top-level XLEN/REG_AW
  // parameters are expected to match these.
  localparam int unsigned SB_XLEN   = 32;
  localparam int unsigned SB_REG_AW = 5;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_FORBID   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EC_NONE     = ERR_NONE,
    EC_MISMATCH = ERR_MISMATCH,
    EC_TIMEOUT  = ERR_TIMEOUT,
    EC_FORBID   = ERR_FORBID
  } err_code_t;

  typedef struct packed {
    logic [SB_REG_AW-1:0] rd;
    logic [SB_XLEN-1:0]   data;
    logic [SB_XLEN-1:0]   mask;
  } exp_entry_t;

  // An observed writeback matches when the register agrees and every masked bit agrees.
  function automatic logic entry_match(input exp_entry_t e,
                                       input logic [SB_REG_AW-1:0] rd,
                                       input logic [SB_XLEN-1:0] data);
    return (rd == e.rd) && (((data ^ e.data) & e.mask) == '0);
  endfunction

endpackage

// File: rtl/wb_sb_exp_table.sv
// Expected-entry storage: one synchronous write port, one asynchronous read
// port. Contents are not reset.
module wb_sb_exp_table
  import wb_sb_pkg::*;
#(
  parameter  int unsigned NUM_CHECKS = 16,
  localparam int unsigned IDX_W      = $clog2(NUM_CHECKS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  exp_entry_t       wentry_i,
  input  logic [IDX_W-1:0] ridx_i,
  output exp_entry_t       rentry_o
);

  exp_entry_t mem_q [NUM_CHECKS];

  // Table write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wentry_i;
    end
  end

  assign rentry_o = mem_q[ridx_i];

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback scoreboard: checks the regfile write stream against an in-order
// table of expected (rd, data, mask) entries with a RUN-cycle watchdog.
// Optional feature macro: WB_SB_FORBID_EN adds a forbid_mask input that fails
// the run on any writeback to a flagged register.
module wb_scoreboard
  import wb_sb_pkg::*;
#(
  parameter  int unsigned NUM_CHECKS     = 16,
  parameter  int unsigned XLEN           = SB_XLEN,
  parameter  int unsigned REG_AW         = SB_REG_AW,
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IDX_W          = $clog2(NUM_CHECKS),
  localparam int unsigned CNT_W          = $clog2(NUM_CHECKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef WB_SB_FORBID_EN
  input  logic [2**REG_AW-1:0] forbid_mask,
`endif
  input  logic                 exp_we,
  input  logic [IDX_W-1:0]     exp_idx,
  input  logic [REG_AW-1:0]    exp_rd,
  input  logic [XLEN-1:0]      exp_data,
  input  logic [XLEN-1:0]      exp_mask,
  input  logic [CNT_W-1:0]     exp_count,
  input  logic                 start,
  input  logic                 wb_en,
  input  logic [REG_AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           err_code,
  output logic [IDX_W-1:0]     err_idx,
  output logic [REG_AW-1:0]    err_rd,
  output logic [XLEN-1:0]      err_data,
  output logic [31:0]          cycle_cnt
);

  state_t            state_q,    state_d;
  logic [IDX_W-1:0]  ptr_q,      ptr_d;
  logic [CNT_W-1:0]  cnt_lim_q,  cnt_lim_d;
  logic [31:0]       cyc_q,      cyc_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              pass_q,     pass_d;
  err_code_t         err_code_q, err_code_d;
  logic [IDX_W-1:0]  err_idx_q,  err_idx_d;
  logic [REG_AW-1:0] err_rd_q,   err_rd_d;
  logic [XLEN-1:0]   err_data_q, err_data_d;

  exp_entry_t        wr_entry;
  exp_entry_t        cur_entry;
  logic              wb_valid;
  logic              match;
  logic              forbid_hit;
  logic              timeout;
  logic [31:0]       cyc_inc;
  logic [CNT_W-1:0]  ptr_inc;
  logic [CNT_W-1:0]  count_in;

  assign wr_entry = '{rd:   SB_REG_AW'(exp_rd),
                      data: SB_XLEN'(exp_data),
                      mask: SB_XLEN'(exp_mask)};

  wb_sb_exp_table #(
    .NUM_CHECKS (NUM_CHECKS)
  ) u_table (
    .clk      (clk),
    .we_i     (exp_we && (state_q != RUN)),
    .widx_i   (exp_idx),
    .wentry_i (wr_entry),
    .ridx_i   (ptr_q),
    .rentry_o (cur_entry)
  );

  // x0 writes are architecturally discarded, so they never count as writebacks.
  assign wb_valid = wb_en && (wb_rd != '0);
  assign match    = entry_match(cur_entry, SB_REG_AW'(wb_rd), SB_XLEN'(wb_data));
  assign ptr_inc  = CNT_W'(ptr_q) + CNT_W'(1);
  assign cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
  assign timeout  = (cyc_inc >= 32'(TIMEOUT_CYCLES));
  assign count_in = (exp_count > CNT_W'(NUM_CHECKS)) ? CNT_W'(NUM_CHECKS) : exp_count;

`ifdef WB_SB_FORBID_EN
  assign forbid_hit = wb_valid && forbid_mask[wb_rd];
`else
  assign forbid_hit = 1'b0;
`endif

  // Next-state and verdict logic; priority forbid > mismatch > timeout > pass
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_lim_d  = cnt_lim_q;
    cyc_d      = cyc_q;
    pass_d     = pass_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    err_rd_d   = err_rd_q;
    err_data_d = err_data_q;

    case (state_q)
      RUN: begin
        cyc_d = cyc_inc;
        if (forbid_hit) begin
          state_d    = FAIL;
          err_code_d = EC_FORBID;
          err_idx_d  = ptr_q;
          err_rd_d   = wb_rd;
          err_data_d = wb_data;
        end else if (wb_valid && (cnt_lim_q != '0) && !match) begin
          state_d    = FAIL;
          err_code_d = EC_MISMATCH;
          err_idx_d  = ptr_q;
          err_rd_d   = wb_rd;
          err_data_d = wb_data;
        end else if (timeout) begin
          state_d    = FAIL;
          err_code_d = EC_TIMEOUT;
          err_idx_d  = ptr_q;
        end else if ((cnt_lim_q == '0) || (wb_valid && (ptr_inc == cnt_lim_q))) begin
          state_d = PASS;
          pass_d  = 1'b1;
        end else if (wb_valid) begin
          ptr_d = IDX_W'(ptr_inc);
        end
      end
      default: begin
        // IDLE, PASS and FAIL all accept a new run
        if (start) begin
          state_d    = RUN;
          ptr_d      = '0;
          cnt_lim_d  = count_in;
          cyc_d      = '0;
          pass_d     = 1'b0;
          err_code_d = EC_NONE;
          err_idx_d  = '0;
          err_rd_d   = '0;
          err_data_d = '0;
        end
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == PASS) || (state_d == FAIL);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_lim_q  <= '0;
      cyc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_code_q <= EC_NONE;
      err_idx_q  <= '0;
      err_rd_q   <= '0;
      err_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_lim_q  <= cnt_lim_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
      err_rd_q   <= err_rd_d;
      err_data_q <= err_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_code  = err_code_q;
  assign err_idx   = err_idx_q;
  assign err_rd    = err_rd_q;
  assign err_data  = err_data_q;
  assign cycle_cnt = cyc_q;

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Synthesizable writeback scoreboard that checks a CPU register-file writeback stream against a loadable table of expected `(rd, data, mask)` entries, in order, with a cycle watchdog. It replaces fixed-delay register peeking with an event-driven pass/fail verdict. It sits beside `cpu_top`, tapping the regfile write port, in both the CPU bench and the SoC bench, and can be kept in silicon as a self-test monitor.

## Interface
- `NUM_CHECKS`, 16: depth of the expected table.
- `XLEN`, 32: data width.
- `REG_AW`, 5: register address width.
- `TIMEOUT_CYCLES`, 1024: RUN cycles allowed before a timeout verdict.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `exp_we` in 1: write one expected-table entry.
- `exp_idx` in $clog2(NUM_CHECKS): entry index.
- `exp_rd` in REG_AW: expected destination register.
- `exp_data` in XLEN: expected value.
- `exp_mask` in XLEN: compare mask; 1 = bit compared.
- `exp_count` in $clog2(NUM_CHECKS+1): number of entries used; sampled at `start`.
- `start` in 1: one-cycle pulse that begins a check run.
- `wb_en` in 1: regfile write enable tap.
- `wb_rd` in REG_AW: regfile write address tap.
- `wb_data` in XLEN: regfile write data tap.
- `busy` out 1: high in RUN.
- `done` out 1: high in PASS or FAIL.
- `pass` out 1: verdict is pass.
- `err_code` out 2: 0 none, 1 mismatch, 2 timeout, 3 forbidden write.
- `err_idx` out $clog2(NUM_CHECKS): entry index at failure.
- `err_rd` out REG_AW: offending register.
- `err_data` out XLEN: offending data.
- `cycle_cnt` out 32: RUN cycles elapsed; frozen once `done` is high.

## Operation
- States: IDLE, RUN, PASS, FAIL.
- Reset: state IDLE; every output 0; table contents undefined.
- Table writes are accepted in IDLE, PASS and FAIL. `exp_we` in RUN is ignored.
- `start` in IDLE, PASS or FAIL:
  - clears the pointer, `cycle_cnt`, `err_*` and `pass`;
  - latches `exp_count`;
  - moves to RUN.
- `start` in RUN is ignored.
- In RUN, a writeback is a cycle with `wb_en=1` and `wb_rd!=0`. Writes to x0 are ignored.
- For each writeback, compare against entry[ptr]:
  - match = `wb_rd==exp_rd && ((wb_data^exp_data)&exp_mask)==0`;
  - match: ptr+1; when ptr+1 equals `exp_count`, go to PASS;
  - no match: go to FAIL with `err_code=1`, `err_idx=ptr`, `err_rd=wb_rd`, `err_data=wb_data`.
- `exp_count==0`: RUN goes to PASS on the first RUN cycle.
- Timeout: `cycle_cnt` reaches TIMEOUT_CYCLES in RUN → FAIL, `err_code=2`, `err_idx=ptr`.
- Same-cycle priority: forbidden over mismatch, mismatch over timeout, timeout over pass.
- PASS and FAIL are sticky until `start` or reset. Writebacks in these states are ignored.
- `rst_n` low mid-run: immediate return to IDLE with all outputs 0.

## Timing
- Writeback inputs are registered-compared: the verdict appears on the clock edge that samples the final writeback, and `done`/`pass` are visible the following cycle.
- `start` → `busy=1` one cycle later.
- `cycle_cnt` increments once per RUN cycle, starting at 0 on the first RUN cycle, and saturates at 2^32-1.
- One writeback per cycle is sustained with no backpressure. The tapped CPU is never stalled.

## Configuration
- `WB_SB_FORBID_EN` defined:
  - adds input `forbid_mask`, 2^REG_AW bits wide;
  - any RUN writeback to rd with `forbid_mask[rd]=1` → FAIL, `err_code=3`. Use case: a branch-skipped register that must never be written.
- `WB_SB_FORBID_EN` undefined:
  - no `forbid_mask` port;
  - `err_code` never takes the value 3.

## Structure
- `wb_sb_pkg` holds:
  - `state_t` enum (IDLE, RUN, PASS, FAIL);
  - `err_code_t` enum;
  - `exp_entry_t` struct (rd, data, mask);
  - `ERR_*` localparams.
- Sub-module `wb_sb_exp_table`: NUM_CHECKS × `exp_entry_t` register array with one write port and one asynchronous read port indexed by ptr. The FSM and counters live in `wb_scoreboard`.

## Test plan
- Load 7 entries: x1=5, x2=10, x3=15, x4=1, x5=0, x6=15, x8=42, all with full mask. Drive that writeback sequence after `start` → `pass=1`, `err_code=0`.
- Same load, but drive x3=14 → `done=1`, `pass=0`, `err_code=1`, `err_idx=2`, `err_rd=3`, `err_data=14`.
- TIMEOUT_CYCLES=16, only 3 of 7 writebacks driven → FAIL at `cycle_cnt=16`, `err_code=2`, `err_idx=3`.
- Entry x7 with `exp_mask=0xFFFFFF00`, drive x7=0x12 → match. Interleaved x0 writes are ignored; a `start` pulse in RUN is ignored.
- `WB_SB_FORBID_EN` with `forbid_mask[7]=1`, drive x7=99 → `err_code=3`, `err_rd=7`. Same cycle also a mismatch → code 3 still wins.
- Assert `rst_n=0` mid-RUN after 2 matches → all outputs 0 and IDLE. A new `start` reruns and passes from entry 0.
